cache_line_arbiter_n: RTL

Parametrised N-requester cacheline arbiter between the L1 caches (icache, dcache, and any future prefetcher or victim buffer) and the single cacheline adaptor that drives burst memory. It accepts one full-line read or write from one requester at a time and forwards it downstream with registered outputs. It returns the line and a one-cycle response pulse to the granted requester only. Successor to the fixed two-port icache/dcache arbiter: it adds a configurable port count and line width, round-robin fairness, and fully registered request and response paths.

---
 rtl/cache_line_arbiter_n_if.sv | 34 +++
 rtl/cache_line_arbiter_n.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cache_line_arbiter_n_if.sv
// cache_line_arbiter_n_if: request-side and memory-side bus of the cacheline arbiter.
// The arbiter uses the slave modport (it serves requesters and drives the adaptor);
// the environment around it (requesters plus adaptor) uses the master modport.
interface cache_line_arbiter_n_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
);
  // Requester side: per-port flattened vectors, port i at [i*W +: W].
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]           req_rdata;
  logic [NUM_PORTS-1:0]        req_resp;

  // Adaptor side.
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_read;
  logic                        mem_write;
  logic [LINE_W-1:0]           mem_wdata;
  logic [LINE_W-1:0]           mem_rdata;
  logic                        mem_resp;

  modport slave (
    input  req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cache_line_arbiter_n.sv
// cache_line_arbiter_n: N-requester full-line arbiter in front of one cacheline adaptor.
// One transaction at a time; all outputs registered; one-cycle response to the winner.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin arbitration with a rotating pointer
//   undefined -> fixed priority, lowest requesting index wins
module cache_line_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_line_arbiter_n_if.slave bus,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [LINE_W-1:0]     req_rdata_q, req_rdata_d;
  logic [NUM_PORTS-1:0]  req_resp_q, req_resp_d;

  logic [NUM_PORTS-1:0]  req_any;
  logic                  req_found;
  logic [ID_W-1:0]       sel_idx;

`ifdef MEM_ARB_RR_EN
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  int                    rr_idx;
`endif

  // A port is requesting on read, write or both (both counts as a write later).
  assign req_any = bus.req_read | bus.req_write;

  // Choose the winning port among the current requesters.
  always_comb begin
    req_found = 1'b0;
    sel_idx   = '0;
`ifdef MEM_ARB_RR_EN
    rr_idx    = 0;
    // Search starts at the pointer and wraps around the port range.
    for (int k = 0; k < NUM_PORTS; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!req_found && req_any[rr_idx]) begin
        req_found = 1'b1;
        sel_idx   = ID_W'(rr_idx);
      end
    end
`else
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req_found && req_any[i]) begin
        req_found = 1'b1;
        sel_idx   = ID_W'(i);
      end
    end
`endif
  end

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    req_rdata_d = req_rdata_q;
    req_resp_d  = '0;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d     = BUSY;
          busy_d      = 1'b1;
          grant_d     = sel_idx;
          mem_addr_d  = bus.req_addr[sel_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.req_wdata[sel_idx*LINE_W +: LINE_W];
          mem_write_d = bus.req_write[sel_idx];
          mem_read_d  = ~bus.req_write[sel_idx];
`ifdef MEM_ARB_RR_EN
          rr_ptr_d    = (sel_idx == ID_W'(NUM_PORTS - 1)) ? '0 : sel_idx + ID_W'(1);
`endif
        end
      end
      BUSY: begin
        // Request inputs are ignored here; only the adaptor completion matters.
        if (bus.mem_resp) begin
          state_d             = DONE;
          req_rdata_d         = bus.mem_rdata;
          mem_read_d          = 1'b0;
          mem_write_d         = 1'b0;
          req_resp_d[grant_q] = 1'b1;
        end
      end
      DONE: begin
        // No arbitration here, so a requester dropping at this edge is never re-granted.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      req_rdata_q <= '0;
      req_resp_q  <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      req_rdata_q <= req_rdata_d;
      req_resp_q  <= req_resp_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.req_rdata = req_rdata_q;
  assign bus.req_resp  = req_resp_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;

  // Structural invariants of the registered outputs.
  a_resp_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.req_resp));
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(bus.mem_read && bus.mem_write));
  a_resp_busy: assert property (@(posedge clk) disable iff (!rst) (|bus.req_resp) |-> busy);

endmodule
